// File: rtl/router_pkt_fifo.sv
// Packet-aware byte FIFO: stores {header flag, byte}, tracks packet framing on the read side.
// Optional parity checking is enabled by defining ROUTER_PKT_FIFO_PARITY_EN.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     ifd_state,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic                     pkt_abort,
  output logic                     parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = DATA_W - 2;
  localparam int EW = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  function automatic logic [LW-1:0] hdr_len(input logic [DATA_W-1:0] b);
    return b[DATA_W-1:2];
  endfunction

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [EW-1:0]     rd_entry;
  logic              rd_hdr;
  logic [DATA_W-1:0] rd_byte;
  state_t            state;
  state_t            state_nx;
  logic [LW-1:0]     remaining;
  logic [LW-1:0]     remaining_nx;
  logic              done_nx;
  logic              abort_nx;

  assign empty       = (count == {CW{1'b0}});
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(DEPTH - AF_MARGIN));
  assign do_wr       = write_enb && !full;
  assign do_rd       = read_enb && !empty;
  assign rd_entry    = mem[rd_ptr];
  assign rd_hdr      = rd_entry[DATA_W];
  assign rd_byte     = rd_entry[DATA_W-1:0];

`ifdef ROUTER_PKT_FIFO_PARITY_EN
  function automatic logic [DATA_W-1:0] par_fold(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc ^ b;
  endfunction

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nx;
  logic              perr_nx;
  logic              perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  // Read-side packet framing: next state, remaining length and pulse decode
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    done_nx      = 1'b0;
    abort_nx     = 1'b0;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
    acc_nx       = acc;
    perr_nx      = 1'b0;
`endif
    if (do_rd) begin
      if (rd_hdr) begin
        // A header always restarts framing; only a header arriving mid-packet aborts
        abort_nx     = (state != IDLE);
        remaining_nx = hdr_len(rd_byte);
        state_nx     = (hdr_len(rd_byte) != {LW{1'b0}}) ? PAYLOAD : PARITY;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
        acc_nx       = rd_byte;
`endif
      end else begin
        case (state)
          IDLE: begin
            state_nx = IDLE;
          end
          PAYLOAD: begin
            remaining_nx = remaining - LW'(1);
            state_nx     = (remaining == LW'(1)) ? PARITY : PAYLOAD;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
            acc_nx       = par_fold(acc, rd_byte);
`endif
          end
          PARITY: begin
            done_nx  = 1'b1;
            state_nx = IDLE;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
            perr_nx  = (acc != rd_byte);
`endif
          end
          default: begin
            state_nx = IDLE;
          end
        endcase
      end
    end else begin
      state_nx = state;
    end
  end

  // Storage array; a flush cycle never writes
  always_ff @(posedge clock) begin
    if (do_wr && resetn && !soft_reset) begin
      mem[wr_ptr] <= {ifd_state, data_in};
    end
  end

  // Pointers, occupancy, read data, framing state and pulses
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      count      <= {CW{1'b0}};
      data_out   <= {DATA_W{1'b0}};
      data_valid <= 1'b0;
      state      <= IDLE;
      remaining  <= {LW{1'b0}};
      pkt_done   <= 1'b0;
      pkt_abort  <= 1'b0;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
      acc        <= {DATA_W{1'b0}};
      perr       <= 1'b0;
`endif
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (do_rd) data_out <= rd_byte;
      data_valid <= do_rd;
      state      <= state_nx;
      remaining  <= remaining_nx;
      pkt_done   <= done_nx;
      pkt_abort  <= abort_nx;
`ifdef ROUTER_PKT_FIFO_PARITY_EN
      acc        <= acc_nx;
      perr       <= perr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: expected bytes and pulses are queued at write time
// and compared as data_valid appears.
module tb_router_pkt_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic [7:0] data_in;
  logic       ifd_state;
  logic       read_enb;
  logic [7:0] data_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       pkt_done;
  logic       pkt_abort;
  logic       parity_err;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_MARGIN(2)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .data_in(data_in), .ifd_state(ifd_state),
    .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .pkt_done(pkt_done), .pkt_abort(pkt_abort), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

`ifdef ROUTER_PKT_FIFO_PARITY_EN
  localparam logic PERR_BAD = 1'b1;
`else
  localparam logic PERR_BAD = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       done;
    logic       abort;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pop scoreboard on every data_valid, otherwise pulses must be quiet
  always @(negedge clock) begin
    if (mon_en) begin
      if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out",   {24'd0, data_out}, {24'd0, e.b});
          check("pkt_done",   {31'd0, pkt_done}, {31'd0, e.done});
          check("pkt_abort",  {31'd0, pkt_abort}, {31'd0, e.abort});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end else begin
        check("pulse_idle", {29'd0, pkt_done, pkt_abort, parity_err}, 32'd0);
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic done, input logic abort, input logic perr);
    exp_t e;
    e.b = b; e.done = done; e.abort = abort; e.perr = perr;
    sb.push_back(e);
  endtask

  task automatic wr(input logic hdr, input logic [7:0] b);
    ifd_state = hdr;
    data_in   = b;
    write_enb = 1'b1;
    @(posedge clock); #1;
    write_enb = 1'b0;
    ifd_state = 1'b0;
  endtask

  task automatic rd(input int n);
    read_enb = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    read_enb = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    data_in = 8'h00; ifd_state = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_af", {31'd0, almost_full}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Fill to full, check thresholds, then one overflow write
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 8'(8'h20 + i));
      push(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      check("fill_count", {27'd0, count}, i + 1);
      check("fill_af", {31'd0, almost_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_full", {31'd0, full}, (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    wr(1'b0, 8'hFF);
    check("ovf_count", {27'd0, count}, 32'd16);
    rd(16);
    drain_check("fill");

    // Good packet: header 0x0C (LEN=3), parity 0x0C
    wr(1'b1, 8'h0C); push(8'h0C, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h11); push(8'h11, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h22); push(8'h22, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h33); push(8'h33, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h0C); push(8'h0C, 1'b1, 1'b0, 1'b0);
    rd(5);
    drain_check("pkt_ok");

    // Same packet, wrong parity byte
    wr(1'b1, 8'h0C); push(8'h0C, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h11); push(8'h11, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h22); push(8'h22, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h33); push(8'h33, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h00); push(8'h00, 1'b1, 1'b0, PERR_BAD);
    rd(5);
    drain_check("pkt_bad");

    // Header LEN=4 interrupted after 2 payload bytes by header 0x04 (LEN=1)
    wr(1'b1, 8'h10); push(8'h10, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'hA1); push(8'hA1, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'hA2); push(8'hA2, 1'b0, 1'b0, 1'b0);
    wr(1'b1, 8'h04); push(8'h04, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 8'hB1); push(8'hB1, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'hB5); push(8'hB5, 1'b1, 1'b0, 1'b0);
    rd(6);
    drain_check("abort");

    // Simultaneous write/read at count 5
    for (int i = 0; i < 5; i++) begin
      wr(1'b0, 8'(8'h51 + i));
      push(8'(8'h51 + i), 1'b0, 1'b0, 1'b0);
    end
    data_in = 8'h56; ifd_state = 1'b0; write_enb = 1'b1; read_enb = 1'b1;
    push(8'h56, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    write_enb = 1'b0; read_enb = 1'b0;
    check("rw5_count", {27'd0, count}, 32'd5);
    rd(5);
    drain_check("rw5");

    // Simultaneous write/read on empty: no bypass
    data_in = 8'h77; write_enb = 1'b1; read_enb = 1'b1;
    push(8'h77, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    write_enb = 1'b0; read_enb = 1'b0;
    check("rw0_count", {27'd0, count}, 32'd1);
    check("rw0_valid", {31'd0, data_valid}, 32'd0);
    rd(1);
    drain_check("rw0");

    // Soft reset mid-packet with 12 entries and a concurrent write
    wr(1'b1, 8'h3C); push(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      wr(1'b0, 8'(8'h60 + i));
      push(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    end
    rd(2);
    check("pre_srst_count", {27'd0, count}, 32'd12);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h99;
    @(posedge clock); #1;
    soft_reset = 1'b0; write_enb = 1'b0;
    sb.delete();
    check("srst_count", {27'd0, count}, 32'd0);
    check("srst_empty", {31'd0, empty}, 32'd1);
    check("srst_valid", {31'd0, data_valid}, 32'd0);
    // A LEN=0 packet must frame cleanly (no abort) if the FSM really returned to IDLE
    wr(1'b1, 8'h00); push(8'h00, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 8'h00); push(8'h00, 1'b1, 1'b0, 1'b0);
    rd(2);
    drain_check("srst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
